// File: rtl/fft_stage_scheduler_if.sv
// Handshake and address bus between the FFT stage scheduler and the
// sample RAM / butterfly unit / twiddle mux bank it sequences.
interface fft_stage_scheduler_if #(
    parameter int LOG2N = 5,
    parameter int STG_W = 3
);
    logic             start;
    logic             ready;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic             bf_valid;
    logic [LOG2N-2:0] tw_idx;
    logic [STG_W-1:0] stage;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    // The scheduler drives the schedule and accepts start.
    modport master (
        input  start,
        output ready, busy, done,
        output rd_en, rd_addr_a, rd_addr_b,
        output bf_valid, tw_idx, stage,
        output wr_en, wr_addr_a, wr_addr_b
    );

    // The datapath side requests transforms and follows the schedule.
    modport slave (
        output start,
        input  ready, busy, done,
        input  rd_en, rd_addr_a, rd_addr_b,
        input  bf_valid, tw_idx, stage,
        input  wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_stage_scheduler.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT. Each transform
// walks LOG2N stages of 2^(LOG2N-1) butterflies, issuing one read pair per
// cycle, the aligned twiddle exponent, and the write-back G cycles later.
// A G-cycle gap between stages keeps every read behind the previous
// stage's write of the same location.
module fft_stage_scheduler #(
    parameter int LOG2N  = 5,
    parameter int BF_LAT = 2,
    parameter int STG_W  = 3
) (
    input  logic                  clk2,
    input  logic                  rst,
    fft_stage_scheduler_if.master bus
);
    localparam int G    = 1 + BF_LAT;          // read latency + butterfly latency
    localparam int NBF  = 1 << (LOG2N - 1);    // butterflies per stage
    localparam int K_W  = LOG2N - 1;
    localparam int GC_W = $clog2(G + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, GAP, FLUSH, DONE} state_t;

    state_t           state_reg, state_next;
    logic [K_W-1:0]   k_reg, k_next;
    logic [STG_W-1:0] s_reg, s_next;
    logic [GC_W-1:0]  g_reg, g_next;

    // Read-side registers (aligned with rd_en)
    logic             rd_en_reg;
    logic [LOG2N-1:0] rd_a_reg, rd_b_reg;
    logic [K_W-1:0]   tw_rd_reg;
    logic [STG_W-1:0] stg_rd_reg;
    // Butterfly-input registers (one cycle behind the read)
    logic             bf_valid_reg;
    logic [K_W-1:0]   tw_reg;
    logic [STG_W-1:0] stage_reg;
    // Write-back delay line, G entries deep
    logic             wr_en_pipe_reg [G];
    logic [LOG2N-1:0] wr_a_pipe_reg  [G];
    logic [LOG2N-1:0] wr_b_pipe_reg  [G];
    // Control outputs
    logic             ready_reg, busy_reg, done_reg;

    // Butterfly address/twiddle for the current (s, k)
    logic [LOG2N-1:0] span_c, grp_c, pos_c, addr_a_c, addr_b_c;
    logic [K_W-1:0]   tw_c;

    // Next-state and counter logic for the stage walk
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        s_next     = s_reg;
        g_next     = g_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = ISSUE;
                    k_next     = '0;
                    s_next     = '0;
                end
            end
            ISSUE: begin
                if (k_reg == K_W'(NBF - 1)) begin
                    g_next     = '0;
                    state_next = (s_reg == STG_W'(LOG2N - 1)) ? FLUSH : GAP;
                end else begin
                    k_next = k_reg + K_W'(1);
                end
            end
            GAP: begin
                if (g_reg == GC_W'(G - 1)) begin
                    state_next = ISSUE;
                    s_next     = s_reg + STG_W'(1);
                    k_next     = '0;
                end else begin
                    g_next = g_reg + GC_W'(1);
                end
            end
            FLUSH: begin
                if (g_reg == GC_W'(G - 1)) begin
                    state_next = DONE;
                end else begin
                    g_next = g_reg + GC_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address pair and twiddle exponent: insert a zero at bit s of k
    always_comb begin
        span_c   = LOG2N'(1) << s_reg;
        grp_c    = LOG2N'(k_reg) >> s_reg;
        pos_c    = LOG2N'(k_reg) & (span_c - LOG2N'(1));
        addr_a_c = (grp_c << (s_reg + STG_W'(1))) + pos_c;
        addr_b_c = addr_a_c + span_c;
        tw_c     = K_W'(pos_c) << (STG_W'(LOG2N - 1) - s_reg);
    end

    // State and counter registers
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            s_reg     <= '0;
            g_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            s_reg     <= s_next;
            g_reg     <= g_next;
        end
    end

    // Read issue; addresses and tags hold while no read is issued
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            rd_en_reg  <= 1'b0;
            rd_a_reg   <= '0;
            rd_b_reg   <= '0;
            tw_rd_reg  <= '0;
            stg_rd_reg <= '0;
        end else begin
            rd_en_reg <= (state_reg == ISSUE);
            if (state_reg == ISSUE) begin
                rd_a_reg   <= addr_a_c;
                rd_b_reg   <= addr_b_c;
                tw_rd_reg  <= tw_c;
                stg_rd_reg <= s_reg;
            end
        end
    end

    // One-cycle delay to the butterfly input (RAM read latency)
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            bf_valid_reg <= 1'b0;
            tw_reg       <= '0;
            stage_reg    <= '0;
        end else begin
            bf_valid_reg <= rd_en_reg;
            tw_reg       <= tw_rd_reg;
            stage_reg    <= stg_rd_reg;
        end
    end

    // Write-back delay line: entry gi holds the read issued gi+1 cycles ago
    genvar gi;
    generate
        for (gi = 0; gi < G; gi++) begin : g_wr_dly
            if (gi == 0) begin : g_head
                // Head entry captures the read strobe and address pair
                always_ff @(posedge clk2 or posedge rst) begin
                    if (rst) begin
                        wr_en_pipe_reg[gi] <= 1'b0;
                        wr_a_pipe_reg[gi]  <= '0;
                        wr_b_pipe_reg[gi]  <= '0;
                    end else begin
                        wr_en_pipe_reg[gi] <= rd_en_reg;
                        wr_a_pipe_reg[gi]  <= rd_a_reg;
                        wr_b_pipe_reg[gi]  <= rd_b_reg;
                    end
                end
            end else begin : g_tail
                // Later entries shift the previous entry along
                always_ff @(posedge clk2 or posedge rst) begin
                    if (rst) begin
                        wr_en_pipe_reg[gi] <= 1'b0;
                        wr_a_pipe_reg[gi]  <= '0;
                        wr_b_pipe_reg[gi]  <= '0;
                    end else begin
                        wr_en_pipe_reg[gi] <= wr_en_pipe_reg[gi-1];
                        wr_a_pipe_reg[gi]  <= wr_a_pipe_reg[gi-1];
                        wr_b_pipe_reg[gi]  <= wr_b_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Handshake outputs; ready drops in the cycle after start is taken
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            ready_reg <= (state_reg == IDLE) && (state_next == IDLE);
            busy_reg  <= (state_reg != IDLE);
            done_reg  <= (state_reg == DONE);
        end
    end

    assign bus.ready     = ready_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.rd_en     = rd_en_reg;
    assign bus.rd_addr_a = rd_a_reg;
    assign bus.rd_addr_b = rd_b_reg;
    assign bus.bf_valid  = bf_valid_reg;
    assign bus.tw_idx    = tw_reg;
    assign bus.stage     = stage_reg;
    assign bus.wr_en     = wr_en_pipe_reg[G-1];
    assign bus.wr_addr_a = wr_a_pipe_reg[G-1];
    assign bus.wr_addr_b = wr_b_pipe_reg[G-1];
endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench for fft_stage_scheduler: each launch pushes the full
// expected read schedule; reads spawn expected butterfly and write-back
// events, all popped and compared as the DUT produces them.
module tb_fft_stage_scheduler;
    localparam int LOG2N = 5;
    localparam int STG_W = 3;
    localparam int NST   = 5;
    localparam int NBF   = 16;
    localparam int G     = 3;
    localparam int RUN   = 96;

    logic clk2 = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;

    fft_stage_scheduler_if #(.LOG2N(LOG2N), .STG_W(STG_W)) bus();

    fft_stage_scheduler #(.LOG2N(LOG2N), .BF_LAT(2), .STG_W(STG_W)) dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk2 = ~clk2;
    always @(posedge clk2) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int s;
        int k;
        int a;
        int b;
        int tw;
    } ev_t;

    ev_t rdq[$];
    ev_t bfq[$];
    ev_t wrq[$];
    int  doneq[$];
    int  wcnt [NST][32];
    int  nrd, nbf, nwr, ndone;
    int  n_cmp = 0;
    int  n_bad = 0;

    // Spot values worked out by hand: (stage, k) -> (a, b, tw)
    int sp_s [5] = '{0, 0, 2, 4, 1};
    int sp_k [5] = '{0, 15, 5, 7, 3};
    int sp_a [5] = '{0, 30, 9, 7, 5};
    int sp_b [5] = '{1, 31, 13, 23, 7};
    int sp_tw[5] = '{0, 0, 4, 7, 8};

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input int t0, input int s, input int k);
        ev_t e;
        int  lo, hi;
        lo    = k % (1 << s);
        hi    = k / (1 << s);
        e.cyc = t0 + 1 + (NBF + G) * s + k;
        e.s   = s;
        e.k   = k;
        e.a   = hi * (2 << s) + lo;
        e.b   = e.a + (1 << s);
        e.tw  = lo * (16 >> s);
        return e;
    endfunction

    task automatic rst_vals(input string tag);
        chk({tag, "_ready"}, int'(bus.ready), 1);
        chk({tag, "_busy"},  int'(bus.busy), 0);
        chk({tag, "_done"},  int'(bus.done), 0);
        chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
        chk({tag, "_rd_a"},  int'(bus.rd_addr_a), 0);
        chk({tag, "_rd_b"},  int'(bus.rd_addr_b), 0);
        chk({tag, "_bfv"},   int'(bus.bf_valid), 0);
        chk({tag, "_tw"},    int'(bus.tw_idx), 0);
        chk({tag, "_stage"}, int'(bus.stage), 0);
        chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
        chk({tag, "_wr_a"},  int'(bus.wr_addr_a), 0);
        chk({tag, "_wr_b"},  int'(bus.wr_addr_b), 0);
    endtask

    // Called at a negedge; start is sampled at the following edge (cycle 0)
    task automatic launch(output int t0);
        t0 = cyc + 1;
        for (int s = 0; s < NST; s++)
            for (int k = 0; k < NBF; k++)
                rdq.push_back(mk_ev(t0, s, k));
        doneq.push_back(t0 + RUN);
        for (int s = 0; s < NST; s++)
            for (int a = 0; a < 32; a++)
                wcnt[s][a] = 0;
        nrd = 0;
        nbf = 0;
        nwr = 0;
        bus.start = 1'b1;
        @(posedge clk2);
        #1;
        bus.start = 1'b0;
        chk("ready_c0", int'(bus.ready), 0);
    endtask

    task automatic wait_cyc(input int t0, input int n);
        while (cyc < t0 + n) @(negedge clk2);
    endtask

    task automatic finish_checks(input string tag);
        int n;
        chk({tag, "_nrd"}, nrd, 80);
        chk({tag, "_nbf"}, nbf, 80);
        chk({tag, "_nwr"}, nwr, 80);
        chk({tag, "_rdq_left"}, rdq.size(), 0);
        chk({tag, "_bfq_left"}, bfq.size(), 0);
        chk({tag, "_wrq_left"}, wrq.size(), 0);
        for (int s = 0; s < NST; s++) begin
            n = 0;
            for (int a = 0; a < 32; a++)
                if (wcnt[s][a] == 1) n++;
            chk($sformatf("%s_wr_once_s%0d", tag, s), n, 32);
        end
    endtask

    // Monitor: pops expectations as reads, butterfly inputs, writes and done appear
    always @(negedge clk2) begin
        ev_t e;
        if (bus.rd_en === 1'b1) begin
            if (rdq.size() == 0) begin
                chk("rd_extra", 1, 0);
            end else begin
                e = rdq.pop_front();
                nrd++;
                chk("rd_cyc", cyc, e.cyc);
                chk("rd_a", int'(bus.rd_addr_a), e.a);
                chk("rd_b", int'(bus.rd_addr_b), e.b);
                for (int i = 0; i < 5; i++)
                    if (sp_s[i] == e.s && sp_k[i] == e.k) begin
                        chk("spot_a", int'(bus.rd_addr_a), sp_a[i]);
                        chk("spot_b", int'(bus.rd_addr_b), sp_b[i]);
                    end
                if (e.s > 0) begin
                    chk("haz_a", wcnt[e.s-1][e.a], 1);
                    chk("haz_b", wcnt[e.s-1][e.b], 1);
                end
                e.cyc = e.cyc + 1;
                bfq.push_back(e);
                e.cyc = e.cyc + G - 1;
                wrq.push_back(e);
            end
        end
        if (bus.bf_valid === 1'b1) begin
            if (bfq.size() == 0) begin
                chk("bf_extra", 1, 0);
            end else begin
                e = bfq.pop_front();
                nbf++;
                chk("bf_cyc", cyc, e.cyc);
                chk("bf_tw", int'(bus.tw_idx), e.tw);
                chk("bf_stage", int'(bus.stage), e.s);
                for (int i = 0; i < 5; i++)
                    if (sp_s[i] == e.s && sp_k[i] == e.k)
                        chk("spot_tw", int'(bus.tw_idx), sp_tw[i]);
            end
        end
        if (bus.wr_en === 1'b1) begin
            if (wrq.size() == 0) begin
                chk("wr_extra", 1, 0);
            end else begin
                e = wrq.pop_front();
                nwr++;
                chk("wr_cyc", cyc, e.cyc);
                chk("wr_a", int'(bus.wr_addr_a), e.a);
                chk("wr_b", int'(bus.wr_addr_b), e.b);
                wcnt[e.s][e.a]++;
                wcnt[e.s][e.b]++;
                $display("wr   cyc=%0d stage=%0d k=%0d a=%0d b=%0d", cyc, e.s, e.k,
                         bus.wr_addr_a, bus.wr_addr_b);
            end
        end
        if (bus.done === 1'b1) begin
            ndone++;
            if (doneq.size() == 0) chk("done_extra", 1, 0);
            else chk("done_cyc", cyc, doneq.pop_front());
        end else if (doneq.size() > 0 && cyc > doneq[0]) begin
            chk("done_miss", cyc, doneq[0]);
            void'(doneq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3;
        ndone = 0;
        bus.start = 1'b1;
        rst = 1'b1;

        // Reset with start held high: outputs at reset values, nothing issued
        repeat (3) @(negedge clk2);
        rst_vals("rst0");
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (5) @(negedge clk2);
        chk("idle_ready", int'(bus.ready), 1);

        // Reset asserted while idle
        #2 rst = 1'b1;
        #1 rst_vals("rst_idle");
        @(negedge clk2);
        rst = 1'b0;
        repeat (2) @(negedge clk2);

        // Run 1 with ignored starts at cycles 50 and 96, then run 2 at 97
        launch(t0);
        wait_cyc(t0, 1);
        chk("busy_c1", int'(bus.busy), 1);
        wait_cyc(t0, 49);
        bus.start = 1'b1;
        @(negedge clk2);
        bus.start = 1'b0;
        wait_cyc(t0, 95);
        bus.start = 1'b1;
        @(negedge clk2);
        bus.start = 1'b0;
        chk("r1_done_c96", int'(bus.done), 1);
        chk("r1_busy_c96", int'(bus.busy), 1);
        chk("r1_ready_c96", int'(bus.ready), 0);
        finish_checks("r1");
        launch(t1);
        chk("r2_t0", t1, t0 + 97);
        wait_cyc(t1, 96);
        chk("r2_done_c96", int'(bus.done), 1);
        chk("r2_ready_c96", int'(bus.ready), 0);
        @(negedge clk2);
        chk("r2_ready_c97", int'(bus.ready), 1);
        chk("r2_busy_c97", int'(bus.busy), 0);
        finish_checks("r2");
        chk("r2_doneq_left", doneq.size(), 0);
        chk("r2_ndone", ndone, 2);

        // Reset in the middle of stage 2
        repeat (2) @(negedge clk2);
        launch(t2);
        wait_cyc(t2, 40);
        chk("mid_rd_en_c40", int'(bus.rd_en), 1);
        #2;
        rst = 1'b1;
        rdq.delete();
        bfq.delete();
        wrq.delete();
        doneq.delete();
        #1 rst_vals("rst_mid");
        repeat (3) @(negedge clk2);
        chk("rst_mid_wr_en", int'(bus.wr_en), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk2);
        chk("post_rst_ready", int'(bus.ready), 1);

        // Clean run after the aborted one
        launch(t3);
        wait_cyc(t3, 96);
        chk("r4_done_c96", int'(bus.done), 1);
        @(negedge clk2);
        chk("r4_ready_c97", int'(bus.ready), 1);
        finish_checks("r4");
        chk("r4_doneq_left", doneq.size(), 0);
        chk("r4_ndone", ndone, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_stage_scheduler.md
Name: fft_stage_scheduler

Overview:
- Top-level sequencer for the in-place 32-point radix-2 DIT FFT core.
- On a start pulse it walks all 5 stages × 16 butterflies. Each cycle it issues one butterfly read (address pair), the aligned twiddle index for the twiddle muxes, and the delayed write-back (address pair).
- Inserts inter-stage bubbles so no stage reads a location before the previous stage has written it.
- Sits between the sample RAM, the butterfly unit and the twiddle mux bank; replaces free-running mux-select counting with a start/done-handshaked schedule.

Parameters:
- LOG2N, 5, log2 of FFT length; addresses LOG2N bits, butterflies per stage 2^(LOG2N-1).
- BF_LAT, 2, butterfly pipeline latency in cycles, from bf_valid to result valid.
- STG_W, 3, width of stage index output.

Ports:
- clk2  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request one full transform; sampled only when ready=1.
- ready  out  1  high in IDLE only.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse after the final write-back.
- rd_en  out  1  butterfly operand read strobe.
- rd_addr_a  out  LOG2N  upper-leg read address.
- rd_addr_b  out  LOG2N  lower-leg read address.
- bf_valid  out  1  rd_en delayed 1 cycle; operands present at butterfly input (RAM read latency 1).
- tw_idx  out  LOG2N-1  twiddle exponent, aligned with bf_valid.
- stage  out  STG_W  current stage index, aligned with bf_valid.
- wr_en  out  1  write-back strobe = rd_en delayed G = 1+BF_LAT cycles.
- wr_addr_a  out  LOG2N  rd_addr_a delayed G cycles.
- wr_addr_b  out  LOG2N  rd_addr_b delayed G cycles.

Behaviour:
- Reset (async, any time including mid-transform):
  - All outputs 0 except ready=1.
  - FSM goes to IDLE; all delay-line contents cleared.
  - No wr_en may escape after rst asserts.
- FSM states: IDLE, ISSUE, GAP, FLUSH, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge → ISSUE with s=0, k=0.
- ISSUE:
  - rd_en=1 every cycle; k increments 0..15.
  - At k=15: if s<LOG2N-1 → GAP, else → FLUSH.
- GAP:
  - rd_en=0 for exactly G cycles, then ISSUE with s+1, k=0.
- FLUSH:
  - rd_en=0 for G cycles, draining the pipeline; then → DONE.
- DONE:
  - done=1 and busy=1 for one cycle, ready=0; next state IDLE.
- start while not in IDLE (including the DONE cycle) is ignored. No queuing.
- Address generation for stage s, butterfly k (all widths truncated to LOG2N):
  - span = 2^s; grp = k>>s; pos = k & (span-1).
  - rd_addr_a = grp·2·span + pos; rd_addr_b = rd_addr_a + span.
  - tw_idx = pos << (LOG2N-1-s), i.e. W32^tw_idx.
- Addresses hold their last value while rd_en=0.
- Timing for BF_LAT=2, G=3; the edge that accepts start is cycle 0:
  - Stage s reads in cycles 1+19s .. 16+19s.
  - Last read is at cycle 92; last wr_en is at cycle 95.
  - done is high in cycle 96; ready is high again from cycle 97.
  - Totals: 80 rd_en cycles, 80 bf_valid cycles, 80 wr_en cycles per transform.
- Hazard rule: the first read of stage s+1 occurs at least 1 cycle after the last write of stage s. The RAM is not required to provide write-to-read forwarding.
- Output registering:
  - All outputs registered.
  - bf_valid/tw_idx/stage use a 1-stage delay line.
  - wr_* use a G-stage delay line.

Test Plan:
- Reset:
  - Assert rst mid-idle → ready=1, all other outputs 0.
  - Hold start=1 during rst → no transform after release until start is sampled in IDLE.
- Full run (BF_LAT=2), start pulse at cycle 0:
  - rd_en in cycles 1–16, 20–35, 39–54, 58–73, 77–92.
  - Stage 0 k=0 → (0,1), tw 0; stage 0 k=15 → (30,31), tw 0.
  - done only in cycle 96; exactly 80 wr_en.
- Address/twiddle spot checks:
  - Stage 2 k=5 → addr (9,13), tw_idx 4.
  - Stage 4 k=7 → addr (7,23), tw_idx 7.
  - Stage 1 k=3 → addr (5,7), tw_idx 8.
  - wr_addr equals rd_addr exactly 3 cycles later.
- Busy handling:
  - start at cycles 50 and 96 → ignored, single done at cycle 96.
  - start at cycle 97 → second identical sequence, done at cycle 193.
- Reset mid-operation:
  - rst at cycle 40 → outputs immediately at reset values, no further wr_en.
  - After release, start gives a normal 96-cycle run.
- Hazard scoreboard:
  - Across a full run, no rd of stage s+1 touches an address whose stage-s write has not yet occurred.
  - Every address is written exactly once per stage.
